// File: rtl/wr_ptr_pkg.sv
// Shared types and helpers for the multi-word FIFO write-pointer controller.
// bin2gray lives here so the read-side controller can reuse it.
package wr_ptr_pkg;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        RUN  = 2'd1,
        FULL = 2'd2
    } wr_state_e;

    // Pointers are at most 32 bits; callers zero-extend and truncate back.
    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic int clamp_cnt(input int cnt, input int maxw);
        return (cnt > maxw) ? maxw : cnt;
    endfunction

endpackage

// File: rtl/wr_ptr_mw.sv
// Multi-word write-pointer controller: 1..MAXW words per beat, fill level, almost-full flag.
// Define WR_PTR_MW_GRAY_EN to add the registered Gray-coded pointer output o_wptr_gray.
module wr_ptr_mw
    import wr_ptr_pkg::*;
#(
    parameter int ALEN      = 8,
    parameter int MAXW      = 4,
    parameter int AFULL_LVL = (1 << ALEN) - MAXW,
    parameter int CW        = $clog2(MAXW + 1)
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            i_tvalid,
    input  logic [CW-1:0]   i_tcnt,
    output logic            o_tready,
    output logic [ALEN-1:0] o_waddr,
    output logic [ALEN:0]   o_wptr,
    input  logic [ALEN:0]   i_rptr,
    output logic            o_ram_wen,
    output logic [CW-1:0]   o_ram_wcnt,
    output logic [ALEN:0]   o_level,
    output logic            o_afull
`ifdef WR_PTR_MW_GRAY_EN
   ,output logic [ALEN:0]   o_wptr_gray
`endif
);

    localparam int            PW      = ALEN + 1;
    localparam int            DEPTH   = 1 << ALEN;
    localparam logic [PW-1:0] RDY_LVL = PW'(DEPTH - MAXW);

    wr_state_e     state_q;
    logic          tready_q;
    logic [PW-1:0] wptr_q;
    logic [PW-1:0] level_q;
    logic          afull_q;

    logic [CW-1:0] cnt;
    logic          xfer;
    logic          ramWen;
    logic [CW-1:0] ramWcnt;
    logic [PW-1:0] wptr_d;
    logic [PW-1:0] level_d;
    logic          tready_d;
    logic          afull_d;

    assign cnt     = CW'(clamp_cnt(int'(i_tcnt), MAXW));
    assign xfer    = i_tvalid & tready_q;
    assign ramWen  = xfer & (cnt != '0);
    assign ramWcnt = ramWen ? cnt : '0;

    // Level assumes the read pointer never overtakes the write pointer.
    assign wptr_d   = wptr_q + PW'(ramWcnt);
    assign level_d  = wptr_d - i_rptr;
    assign tready_d = (level_d <= RDY_LVL);
    assign afull_d  = (32'(level_d) >= 32'(AFULL_LVL));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= INIT;
            tready_q <= 1'b0;
            wptr_q   <= '0;
            level_q  <= '0;
            afull_q  <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            level_q <= level_d;
            afull_q <= afull_d;
            case (state_q)
                INIT: begin
                    state_q  <= RUN;
                    tready_q <= 1'b1;
                end
                RUN: begin
                    tready_q <= tready_d;
                    if (!tready_d) begin
                        state_q <= FULL;
                    end
                end
                FULL: begin
                    tready_q <= tready_d;
                    if (tready_d) begin
                        state_q <= RUN;
                    end
                end
                default: begin
                    state_q  <= INIT;
                    tready_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef WR_PTR_MW_GRAY_EN
    logic [PW-1:0] gray_q;

    // Driven straight from a flop so it can feed a 2-flop synchroniser.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            gray_q <= '0;
        end else begin
            gray_q <= PW'(bin2gray(32'(wptr_d)));
        end
    end

    assign o_wptr_gray = gray_q;
`endif

    assign o_tready   = tready_q;
    assign o_waddr    = wptr_q[ALEN-1:0];
    assign o_wptr     = wptr_q;
    assign o_ram_wen  = ramWen;
    assign o_ram_wcnt = ramWcnt;
    assign o_level    = level_q;
    assign o_afull    = afull_q;

endmodule

// File: tb/tb_wr_ptr_mw.sv
// Directed, table-driven bench for wr_ptr_mw with DEPTH=8, MAXW=4, AFULL_LVL=6.
// Checks o_wptr_gray as well when WR_PTR_MW_GRAY_EN is defined.
module tb_wr_ptr_mw;

    localparam int ALEN = 3;
    localparam int MAXW = 4;
    localparam int AFUL = 6;
    localparam int CW   = 3;

    logic            clk;
    logic            rstn;
    logic            tValid;
    logic [CW-1:0]   tCnt;
    logic            tReady;
    logic [ALEN-1:0] wAddr;
    logic [ALEN:0]   wPtr;
    logic [ALEN:0]   rPtr;
    logic            ramWen;
    logic [CW-1:0]   ramWcnt;
    logic [ALEN:0]   level;
    logic            aFull;
`ifdef WR_PTR_MW_GRAY_EN
    logic [ALEN:0]   wPtrGray;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic          valid;
        logic [CW-1:0] cnt;
        logic [ALEN:0] rptr;
        int            expWen;
        int            expWcnt;
        int            expWaddr;
        int            expWptr;
        int            expLevel;
        int            expReady;
        int            expAfull;
        int            expGray;
    } vec_t;

    vec_t vecs[16];

    wr_ptr_mw #(
        .ALEN(ALEN),
        .MAXW(MAXW),
        .AFULL_LVL(AFUL)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .i_tvalid(tValid),
        .i_tcnt(tCnt),
        .o_tready(tReady),
        .o_waddr(wAddr),
        .o_wptr(wPtr),
        .i_rptr(rPtr),
        .o_ram_wen(ramWen),
        .o_ram_wcnt(ramWcnt),
        .o_level(level),
        .o_afull(aFull)
`ifdef WR_PTR_MW_GRAY_EN
       ,.o_wptr_gray(wPtrGray)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global time limit so the bench always ends.
    initial begin
        #200000;
        $display("[TB] FAIL timeout actual=running expected=finished");
        $fatal(1, "[TB] time limit expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [CW-1:0] cnt, input logic [ALEN:0] rptr);
        tValid = valid;
        tCnt   = cnt;
        rPtr   = rptr;
    endtask

    task automatic checkRegs(input string tag, input int eWptr, input int eLevel,
                             input int eReady, input int eAfull, input int eGray);
        checkOutput({tag, ".wptr"},   int'(wPtr),   eWptr);
        checkOutput({tag, ".level"},  int'(level),  eLevel);
        checkOutput({tag, ".tready"}, int'(tReady), eReady);
        checkOutput({tag, ".afull"},  int'(aFull),  eAfull);
`ifdef WR_PTR_MW_GRAY_EN
        checkOutput({tag, ".gray"},   int'(wPtrGray), eGray);
`else
        if (eGray < 0) $display("[TB] unexpected gray value %0d", eGray);
`endif
    endtask

    initial begin
        // valid cnt rptr | wen wcnt waddr | wptr level rdy afull gray
        vecs[0]  = '{1'b1, 3'd4, 4'd0,  1, 4, 0,   4,  4, 1, 0,  6};
        vecs[1]  = '{1'b1, 3'd1, 4'd0,  1, 1, 4,   5,  5, 0, 0,  7};
        vecs[2]  = '{1'b1, 3'd4, 4'd0,  0, 0, 5,   5,  5, 0, 0,  7};
        vecs[3]  = '{1'b0, 3'd0, 4'd1,  0, 0, 5,   5,  4, 1, 0,  7};
        vecs[4]  = '{1'b0, 3'd0, 4'd5,  0, 0, 5,   5,  0, 1, 0,  7};
        vecs[5]  = '{1'b1, 3'd4, 4'd9,  1, 4, 5,   9,  0, 1, 0, 13};
        vecs[6]  = '{1'b1, 3'd4, 4'd12, 1, 4, 1,  13,  1, 1, 0, 11};
        vecs[7]  = '{1'b1, 3'd1, 4'd12, 1, 1, 5,  14,  2, 1, 0,  9};
        vecs[8]  = '{1'b1, 3'd3, 4'd12, 1, 3, 6,   1,  5, 0, 0,  1};
        vecs[9]  = '{1'b0, 3'd0, 4'd1,  0, 0, 1,   1,  0, 1, 0,  1};
        vecs[10] = '{1'b1, 3'd0, 4'd1,  0, 0, 1,   1,  0, 1, 0,  1};
        vecs[11] = '{1'b1, 3'd7, 4'd1,  1, 4, 1,   5,  4, 1, 0,  7};
        vecs[12] = '{1'b1, 3'd2, 4'd1,  1, 2, 5,   7,  6, 0, 1,  4};
        vecs[13] = '{1'b0, 3'd0, 4'd3,  0, 0, 7,   7,  4, 1, 0,  4};
        vecs[14] = '{1'b1, 3'd4, 4'd3,  1, 4, 7,  11,  8, 0, 1, 14};
        vecs[15] = '{1'b0, 3'd0, 4'd11, 0, 0, 3,  11,  0, 1, 0, 14};

        // Reset release between edges.
        rstn = 1'b0;
        applyStimulus(1'b0, 3'd0, 4'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkRegs("inReset", 0, 0, 0, 0, 0);
        rstn = 1'b1;
        #1;
        checkOutput("release.tready_pre", int'(tReady), 0);
        @(posedge clk);
        #1;
        checkRegs("release", 0, 0, 1, 0, 0);
        checkOutput("release.wen", int'(ramWen), 0);

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            applyStimulus(vecs[i].valid, vecs[i].cnt, vecs[i].rptr);
            #1;
            checkOutput($sformatf("v%0d.wen", i),   int'(ramWen),  vecs[i].expWen);
            checkOutput($sformatf("v%0d.wcnt", i),  int'(ramWcnt), vecs[i].expWcnt);
            checkOutput($sformatf("v%0d.waddr", i), int'(wAddr),   vecs[i].expWaddr);
            @(posedge clk);
            #1;
            checkRegs($sformatf("v%0d", i), vecs[i].expWptr, vecs[i].expLevel,
                      vecs[i].expReady, vecs[i].expAfull, vecs[i].expGray);
        end

        // Asynchronous reset in the middle of an accepted beat.
        @(negedge clk);
        applyStimulus(1'b1, 3'd2, 4'd11);
        #1;
        checkOutput("arst.wen_before", int'(ramWen), 1);
        #1;
        rstn = 1'b0;
        #1;
        checkOutput("arst.wen", int'(ramWen), 0);
        checkRegs("arst", 0, 0, 0, 0, 0);
        applyStimulus(1'b1, 3'd2, 4'd0);
        @(posedge clk);
        #1;
        checkOutput("arst.tready_hold", int'(tReady), 0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        checkRegs("arst.release", 0, 0, 1, 0, 0);
        @(negedge clk);
        #1;
        checkOutput("arst.wen_after", int'(ramWen), 1);
        checkOutput("arst.waddr_after", int'(wAddr), 0);
        @(posedge clk);
        #1;
        checkRegs("arst.beat", 2, 2, 1, 0, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
